// File: rtl/fp_norm_pack_if.sv
// Handshake bundle between the FP adder align/add datapath and the normalise/pack stage.
interface fp_norm_pack_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign;
  logic [EXP_W-1:0]       in_exp;
  logic [MAN_W+1:0]       in_sum;
  logic                   in_sticky;
  logic                   in_inf;
  logic                   in_nan;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_result;
  logic                   out_overflow;
  logic                   out_underflow;

  modport master (
    output in_valid, in_sign, in_exp, in_sum, in_sticky, in_inf, in_nan, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sum, in_sticky, in_inf, in_nan, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow
  );
endinterface

// File: rtl/fp_norm_pack.sv
// Sequential normalise-and-pack stage of the single-precision FP adder (one left shift per cycle).
// Define FP_NORM_ROUND_EN for round-to-nearest-even on the carry right-shift; default truncates.
module fp_norm_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_norm_pack_if.slave bus
);
  localparam int SW = MAN_W + 2;
  localparam int EW = EXP_W + 1;
  localparam int RW = 1 + EXP_W + MAN_W;
  localparam logic [EW-1:0] E_ONE = EW'(1);
  localparam logic [EW-1:0] E_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [RW-1:0] NAN_W = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SHIFT, S_ROUND, S_DONE} state_t;

  state_t          r_state, w_state_n;
  logic            r_sign, r_nan, r_inf;
  logic [EW-1:0]   r_exp, w_exp_n, w_exp_inc, w_exp_dec;
  logic [SW-1:0]   r_sum, w_sum_n, w_sum_sh;
  logic [RW-1:0]   r_result, w_res, w_inf_word;
  logic            r_ovf, r_unf, w_ovf, w_unf, w_load;
`ifdef FP_NORM_ROUND_EN
  logic            r_sticky, w_rup;
  logic [MAN_W:0]  w_rinc;
  logic [EW-1:0]   w_rexp;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n  = r_state;
    w_load     = 1'b0;
    w_res      = '0;
    w_ovf      = 1'b0;
    w_unf      = 1'b0;
    w_sum_sh   = r_sum << 1;
    w_exp_inc  = r_exp + E_ONE;
    w_exp_dec  = r_exp - E_ONE;
    w_sum_n    = r_sum;
    w_exp_n    = r_exp;
    w_inf_word = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_NORM_ROUND_EN
    w_rup  = r_sum[0] & (r_sticky | r_sum[1]);
    // A carry out of the stored mantissa means 1.111..1 rounded to 10.0: mantissa 0, one more exponent step.
    w_rinc = {1'b0, r_sum[MAN_W:1]} + {{MAN_W{1'b0}}, w_rup};
    w_rexp = w_exp_inc + {{EXP_W{1'b0}}, w_rinc[MAN_W]};
`endif
    unique case (r_state)
      S_IDLE: if (bus.in_valid) w_state_n = S_CHECK;
      S_CHECK: begin
        w_state_n = S_DONE;
        w_load    = 1'b1;
        if (r_nan)              w_res = NAN_W;
        else if (r_inf)         w_res = w_inf_word;
        else if (r_sum == '0)   w_res = '0;
        else if (r_sum[SW-1]) begin
`ifdef FP_NORM_ROUND_EN
          w_state_n = S_ROUND;
          w_load    = 1'b0;
`else
          if (w_exp_inc >= E_MAX) begin
            w_res = w_inf_word;
            w_ovf = 1'b1;
          end else
            w_res = {r_sign, w_exp_inc[EXP_W-1:0], r_sum[MAN_W:1]};
`endif
        end
        else if (r_sum[MAN_W])  w_res = {r_sign, r_exp[EXP_W-1:0], r_sum[MAN_W-1:0]};
        else if (r_exp <= E_ONE) begin
          // Already at the minimum exponent (including denormal inputs): pack as-is.
          w_res = {r_sign, {EXP_W{1'b0}}, r_sum[MAN_W-1:0]};
          w_unf = 1'b1;
        end else begin
          w_state_n = S_SHIFT;
          w_load    = 1'b0;
        end
      end
      S_SHIFT: begin
        w_sum_n = w_sum_sh;
        w_exp_n = w_exp_dec;
        if (w_sum_sh[MAN_W]) begin
          w_state_n = S_DONE;
          w_load    = 1'b1;
          w_res     = {r_sign, w_exp_dec[EXP_W-1:0], w_sum_sh[MAN_W-1:0]};
        end else if (w_exp_dec <= E_ONE) begin
          w_state_n = S_DONE;
          w_load    = 1'b1;
          w_res     = {r_sign, {EXP_W{1'b0}}, w_sum_sh[MAN_W-1:0]};
          w_unf     = 1'b1;
        end
      end
      S_ROUND: begin
        w_state_n = S_DONE;
        w_load    = 1'b1;
`ifdef FP_NORM_ROUND_EN
        if (w_rexp >= E_MAX) begin
          w_res = w_inf_word;
          w_ovf = 1'b1;
        end else
          w_res = {r_sign, w_rexp[EXP_W-1:0], w_rinc[MAN_W-1:0]};
`endif
      end
      S_DONE: if (bus.out_ready) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sign   <= 1'b0;
      r_nan    <= 1'b0;
      r_inf    <= 1'b0;
      r_exp    <= '0;
      r_sum    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
`ifdef FP_NORM_ROUND_EN
      r_sticky <= 1'b0;
`endif
    end else begin
      if (r_state == S_IDLE && bus.in_valid) begin
        r_sign <= bus.in_sign;
        r_nan  <= bus.in_nan;
        r_inf  <= bus.in_inf;
        r_sum  <= bus.in_sum;
        // Exponent 0 is a denormal input: its true scale is that of exponent 1.
        r_exp  <= (bus.in_exp == '0) ? E_ONE : {1'b0, bus.in_exp};
`ifdef FP_NORM_ROUND_EN
        r_sticky <= bus.in_sticky;
`endif
      end else begin
        r_sum <= w_sum_n;
        r_exp <= w_exp_n;
      end
      if (w_load) begin
        r_result <= w_res;
        r_ovf    <= w_ovf;
        r_unf    <= w_unf;
      end
    end
  end

  always_comb begin
    bus.in_ready      = (r_state == S_IDLE);
    bus.out_valid     = (r_state == S_DONE);
    bus.out_result    = r_result;
    bus.out_overflow  = r_ovf;
    bus.out_underflow = r_unf;
  end
endmodule

// File: tb/tb_fp_norm_pack.sv
// Table-driven bench for fp_norm_pack with a scoreboard queue of expected results.
module tb_fp_norm_pack;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_norm_pack_if bus();
  fp_norm_pack dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] sum;
    logic        sticky, inf, nan;
    logic [31:0] res;
    logic        ovf, unf;
    int          lat;
  } vec_t;

`ifdef FP_NORM_ROUND_EN
  localparam int CL = 3;
`else
  localparam int CL = 2;
`endif

  vec_t vecs[$];
  vec_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mk(logic s, logic [7:0] e, logic [24:0] m, logic st, logic inf, logic nan,
                              logic [31:0] r, logic ov, logic un, int lat);
    vec_t v;
    v.sign = s; v.exp = e; v.sum = m; v.sticky = st; v.inf = inf; v.nan = nan;
    v.res = r; v.ovf = ov; v.unf = un; v.lat = lat;
    return v;
  endfunction

  // Called at posedge+1 with the DUT idle; holds out_ready low for 'hold' extra cycles once valid.
  task automatic run_vec(input vec_t v, input string tag, input int hold);
    vec_t e;
    int lat;
    chk({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_sign = v.sign; bus.in_exp = v.exp; bus.in_sum = v.sum;
    bus.in_sticky = v.sticky; bus.in_inf = v.inf; bus.in_nan = v.nan;
    bus.in_valid = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    if (!bus.out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.timeout: no out_valid after %0d cycles", tag, lat);
      return;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(e.lat));
    for (int h = 0; h <= hold; h++) begin
      chk({tag, ".res"}, bus.out_result, e.res);
      chk({tag, ".ovf"}, 32'(bus.out_overflow), 32'(e.ovf));
      chk({tag, ".unf"}, 32'(bus.out_underflow), 32'(e.unf));
      chk({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      if (h < hold) begin
        @(posedge clk); #1;
        chk({tag, ".valid_held"}, 32'(bus.out_valid), 32'd1);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_sum = '0;
    bus.in_sticky = 1'b0; bus.in_inf = 1'b0; bus.in_nan = 1'b0; bus.out_ready = 1'b0;

    vecs.push_back(mk(0, 8'd130, 25'h0E00000, 0, 0, 0, 32'h41600000, 0, 0, 2));
    vecs.push_back(mk(0, 8'd129, 25'h1000000, 0, 0, 0, 32'h41000000, 0, 0, CL));
    vecs.push_back(mk(0, 8'd130, 25'h0200000, 0, 0, 0, 32'h40000000, 0, 0, 4));
    vecs.push_back(mk(1, 8'd100, 25'h0000000, 0, 0, 0, 32'h00000000, 0, 0, 2));
    vecs.push_back(mk(0, 8'd255, 25'h0000000, 0, 1, 0, 32'h7F800000, 0, 0, 2));
    vecs.push_back(mk(1, 8'd255, 25'h0000000, 0, 1, 0, 32'hFF800000, 0, 0, 2));
    vecs.push_back(mk(1, 8'd255, 25'h0400000, 0, 1, 1, 32'h7FC00000, 0, 0, 2));
    vecs.push_back(mk(0, 8'd254, 25'h1000000, 0, 0, 0, 32'h7F800000, 1, 0, CL));
    vecs.push_back(mk(0, 8'd2,   25'h0000001, 0, 0, 0, 32'h00000002, 0, 1, 3));
    vecs.push_back(mk(1, 8'd0,   25'h0000010, 0, 0, 0, 32'h80000010, 0, 1, 2));
    vecs.push_back(mk(0, 8'd0,   25'h0800000, 0, 0, 0, 32'h00800000, 0, 0, 2));
    vecs.push_back(mk(0, 8'd10,  25'h0000001, 0, 0, 0, 32'h00000200, 0, 1, 11));
    vecs.push_back(mk(0, 8'd200, 25'h0000001, 0, 0, 0, 32'h58800000, 0, 0, 25));
`ifdef FP_NORM_ROUND_EN
    vecs.push_back(mk(0, 8'd129, 25'h1000003, 0, 0, 0, 32'h41000002, 0, 0, 3));
    vecs.push_back(mk(0, 8'd129, 25'h1000001, 1, 0, 0, 32'h41000001, 0, 0, 3));
    vecs.push_back(mk(0, 8'd129, 25'h1000001, 0, 0, 0, 32'h41000000, 0, 0, 3));
    vecs.push_back(mk(0, 8'd129, 25'h1FFFFFF, 0, 0, 0, 32'h41800000, 0, 0, 3));
    vecs.push_back(mk(0, 8'd253, 25'h1FFFFFF, 0, 0, 0, 32'h7F800000, 1, 0, 3));
`else
    vecs.push_back(mk(0, 8'd129, 25'h1000003, 0, 0, 0, 32'h41000001, 0, 0, 2));
    vecs.push_back(mk(0, 8'd129, 25'h1000001, 1, 0, 0, 32'h41000000, 0, 0, 2));
    vecs.push_back(mk(0, 8'd129, 25'h1FFFFFF, 0, 0, 0, 32'h417FFFFF, 0, 0, 2));
    vecs.push_back(mk(0, 8'd253, 25'h1FFFFFF, 0, 0, 0, 32'h7F7FFFFF, 0, 0, 2));
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.out_result", bus.out_result, 32'h0);
    chk("rst.ovf", 32'(bus.out_overflow), 32'd0);
    chk("rst.unf", 32'(bus.out_underflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i), 0);

    // Backpressure: result must hold for 5 stalled cycles
    run_vec(vecs[0], "hold", 5);

    // Reset during SHIFT aborts the operation
    bus.in_sign = 1'b0; bus.in_exp = 8'd200; bus.in_sum = 25'h0000001;
    bus.in_sticky = 1'b0; bus.in_inf = 1'b0; bus.in_nan = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst.out_result", bus.out_result, 32'h0);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 30; c++) begin
        @(posedge clk); #1;
        if (bus.out_valid) seen++;
      end
      chk("midrst.no_output", 32'(seen), 32'd0);
    end
    run_vec(vecs[2], "post_rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
